// File: rtl/pdh_pkg.sv
// Shared PDH definitions: DAC word layout and pack/unpack helpers used by the
// command core and the DAC slew limiter.
package pdh_pkg;
    localparam int DAC_DATA_WIDTH   = 14;
    localparam int AXIS_TDATA_WIDTH = 32;
    localparam logic [DAC_DATA_WIDTH-1:0] DAC_MID = 14'h2000;

    localparam int CH1_LSB = 0;
    localparam int CH2_LSB = 16;

    typedef logic [DAC_DATA_WIDTH-1:0]   dac_t;
    typedef logic [AXIS_TDATA_WIDTH-1:0] dac_word_t;

    function automatic dac_word_t dac_pack(input dac_t ch1, input dac_t ch2);
        return {2'b00, ch2, 2'b00, ch1};
    endfunction

    function automatic dac_t dac_ch1(input dac_word_t w);
        return w[CH1_LSB +: DAC_DATA_WIDTH];
    endfunction

    function automatic dac_t dac_ch2(input dac_word_t w);
        return w[CH2_LSB +: DAC_DATA_WIDTH];
    endfunction
endpackage

// File: rtl/slew_channel.sv
// One DAC channel: holds the commanded target and walks the output toward it
// by at most `step` codes per tick, landing exactly on the target.
module slew_channel
    import pdh_pkg::*;
(
    input  logic clk,
    input  logic rst_i,
    input  logic load,
    input  dac_t load_val,
    input  logic tick,
    input  dac_t step,
    input  logic immediate,
    output dac_t out,
    output logic at_target
);
    dac_t               tgt_q, tgt_d;
    dac_t               out_q, out_d;
    logic signed [14:0] diff;
    logic        [14:0] mag;

    always_comb begin
        tgt_d = load ? load_val : tgt_q;
        diff  = $signed({1'b0, tgt_q}) - $signed({1'b0, out_q});
        mag   = diff[14] ? $unsigned(-diff) : $unsigned(diff);
        out_d = out_q;
        if (immediate) begin
            out_d = tgt_q;
        end else if (tick && diff != 15'sd0) begin
            // Landing exactly when within one step is what keeps us off the rails.
            if (mag <= {1'b0, step})
                out_d = tgt_q;
            else if (!diff[14])
                out_d = out_q + step;
            else
                out_d = out_q - step;
        end
        at_target = (out_d == tgt_d);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            tgt_q <= DAC_MID;
            out_q <= DAC_MID;
        end else begin
            tgt_q <= tgt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: rtl/dac_slew_limiter.sv
// Turns the sparse PS target stream into a continuous DAC stream whose two
// channels slew toward their targets at a programmable rate.
module dac_slew_limiter
    import pdh_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_tdata_i,
    input  logic                        s_tvalid_i,
    input  logic [DAC_DATA_WIDTH-1:0]   step_i,
    input  logic [DIV_WIDTH-1:0]        div_i,
    input  logic                        bypass_i,
    output logic [AXIS_TDATA_WIDTH-1:0] m_tdata_o,
    output logic                        m_tvalid_o,
    output logic                        busy_o,
    output logic                        settled_o
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick, immediate;
    logic                 busy_q, busy_d, settled_q, vld_q;
    dac_t                 out1, out2;
    logic                 at1, at2;

    assign tick      = (cnt_q == div_i);
    assign immediate = bypass_i || (step_i == '0);

    // A divisor lowered below the running count wraps without producing a tick.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick || cnt_q > div_i)
            cnt_d = '0;
    end

    slew_channel u_ch1 (
        .clk(clk), .rst_i(rst_i), .load(s_tvalid_i), .load_val(dac_ch1(s_tdata_i)),
        .tick(tick), .step(step_i), .immediate(immediate), .out(out1), .at_target(at1)
    );

    slew_channel u_ch2 (
        .clk(clk), .rst_i(rst_i), .load(s_tvalid_i), .load_val(dac_ch2(s_tdata_i)),
        .tick(tick), .step(step_i), .immediate(immediate), .out(out2), .at_target(at2)
    );

    assign busy_d = !(at1 && at2);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            settled_q <= busy_q && !busy_d;
            vld_q     <= 1'b1;
        end
    end

    assign m_tdata_o  = dac_pack(out1, out2);
    assign m_tvalid_o = vld_q;
    assign busy_o     = busy_q;
    assign settled_o  = settled_q;
endmodule

// File: tb/tb_dac_slew_limiter.sv
// Directed bench for dac_slew_limiter; expected values are hand-derived per step.
module tb_dac_slew_limiter;
    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] s_tdata_i;
    logic        s_tvalid_i;
    logic [13:0] step_i;
    logic [15:0] div_i;
    logic        bypass_i;
    logic [31:0] m_tdata_o;
    logic        m_tvalid_o, busy_o, settled_o;

    int n_vec = 0;
    int n_err = 0;

    dac_slew_limiter #(.DIV_WIDTH(16)) dut (
        .clk(clk), .rst_i(rst_i), .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i),
        .step_i(step_i), .div_i(div_i), .bypass_i(bypass_i), .m_tdata_o(m_tdata_o),
        .m_tvalid_o(m_tvalid_o), .busy_o(busy_o), .settled_o(settled_o)
    );

    always #4 clk = ~clk;

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One edge, then check data, valid, busy and settled together.
    task automatic step_chk(input string tag, input logic [31:0] d, input logic v,
                            input logic b, input logic s);
        edge_clk();
        s_tvalid_i = 1'b0;
        chk({tag, ".data"},    m_tdata_o,  d);
        chk({tag, ".valid"},   {31'b0, m_tvalid_o}, {31'b0, v});
        chk({tag, ".busy"},    {31'b0, busy_o},     {31'b0, b});
        chk({tag, ".settled"}, {31'b0, settled_o},  {31'b0, s});
    endtask

    task automatic send(input logic [31:0] w);
        s_tdata_i  = w;
        s_tvalid_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; s_tdata_i = '0; s_tvalid_i = 1'b0;
        step_i = 14'h100; div_i = '0; bypass_i = 1'b0;

        // Reset and hold
        step_chk("rst0", 32'h2000_2000, 1'b0, 1'b0, 1'b0);
        step_chk("rst1", 32'h2000_2000, 1'b0, 1'b0, 1'b0);
        step_chk("rst2", 32'h2000_2000, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        step_chk("post_rst", 32'h2000_2000, 1'b1, 1'b0, 1'b0);

        // Slew up ch1 by 0x100 per cycle
        send(32'h2000_2400);
        step_chk("up_k",  32'h2000_2000, 1'b1, 1'b1, 1'b0);
        step_chk("up_k1", 32'h2000_2100, 1'b1, 1'b1, 1'b0);
        step_chk("up_k2", 32'h2000_2200, 1'b1, 1'b1, 1'b0);
        step_chk("up_k3", 32'h2000_2300, 1'b1, 1'b1, 1'b0);
        step_chk("up_k4", 32'h2000_2400, 1'b1, 1'b0, 1'b1);
        step_chk("up_k5", 32'h2000_2400, 1'b1, 1'b0, 1'b0);

        // Prescaled (tick every 4th edge), non-multiple step on ch2
        div_i = 16'd3; step_i = 14'h300;
        send(32'h1C00_2400);
        step_chk("pre_k",  32'h2000_2400, 1'b1, 1'b1, 1'b0);
        step_chk("pre_k1", 32'h2000_2400, 1'b1, 1'b1, 1'b0);
        step_chk("pre_k2", 32'h2000_2400, 1'b1, 1'b1, 1'b0);
        step_chk("pre_k3", 32'h1D00_2400, 1'b1, 1'b1, 1'b0);
        step_chk("pre_k4", 32'h1D00_2400, 1'b1, 1'b1, 1'b0);
        step_chk("pre_k5", 32'h1D00_2400, 1'b1, 1'b1, 1'b0);
        step_chk("pre_k6", 32'h1D00_2400, 1'b1, 1'b1, 1'b0);
        step_chk("pre_k7", 32'h1C00_2400, 1'b1, 1'b0, 1'b1);
        div_i = '0;

        // Bypass snaps ch1 back to mid-scale in one edge after the latch
        bypass_i = 1'b1;
        send(32'h1C00_2000);
        step_chk("byp_k",  32'h1C00_2400, 1'b1, 1'b1, 1'b0);
        step_chk("byp_k1", 32'h1C00_2000, 1'b1, 1'b0, 1'b1);
        bypass_i = 1'b0;

        // Retarget mid-slew: latch 0x2100 on the edge that produces 0x2400
        step_i = 14'h200;
        send(32'h1C00_3000);
        step_chk("rt_k",  32'h1C00_2000, 1'b1, 1'b1, 1'b0);
        step_chk("rt_k1", 32'h1C00_2200, 1'b1, 1'b1, 1'b0);
        send(32'h1C00_2100);
        step_chk("rt_k2", 32'h1C00_2400, 1'b1, 1'b1, 1'b0);
        step_chk("rt_k3", 32'h1C00_2200, 1'b1, 1'b1, 1'b0);
        step_chk("rt_k4", 32'h1C00_2100, 1'b1, 1'b0, 1'b1);
        step_chk("rt_k5", 32'h1C00_2100, 1'b1, 1'b0, 1'b0);

        // Retarget equal to current output: no busy, no pulse
        send(32'h1C00_2100);
        step_chk("same_k",  32'h1C00_2100, 1'b1, 1'b0, 1'b0);
        step_chk("same_k1", 32'h1C00_2100, 1'b1, 1'b0, 1'b0);

        // Full-scale step reaches the top rail in one tick
        step_i = 14'h3FFF;
        send(32'h1C00_3FFF);
        step_chk("rail_k",  32'h1C00_2100, 1'b1, 1'b1, 1'b0);
        step_chk("rail_k1", 32'h1C00_3FFF, 1'b1, 1'b0, 1'b1);

        // Bypass to opposite rails on both channels
        bypass_i = 1'b1;
        send(32'h3FFF_0000);
        step_chk("brail_k",  32'h1C00_3FFF, 1'b1, 1'b1, 1'b0);
        step_chk("brail_k1", 32'h3FFF_0000, 1'b1, 1'b0, 1'b1);
        step_chk("brail_k2", 32'h3FFF_0000, 1'b1, 1'b0, 1'b0);
        bypass_i = 1'b0;

        // step_i==0 behaves as immediate
        step_i = 14'h0;
        send(32'h2000_2000);
        step_chk("s0_k",  32'h3FFF_0000, 1'b1, 1'b1, 1'b0);
        step_chk("s0_k1", 32'h2000_2000, 1'b1, 1'b0, 1'b1);

        // Reset mid-slew, with a strobe during reset that must be ignored
        step_i = 14'h200;
        send(32'h2000_3000);
        step_chk("rm_k",  32'h2000_2000, 1'b1, 1'b1, 1'b0);
        step_chk("rm_k1", 32'h2000_2200, 1'b1, 1'b1, 1'b0);
        step_chk("rm_k2", 32'h2000_2400, 1'b1, 1'b1, 1'b0);
        step_chk("rm_k3", 32'h2000_2600, 1'b1, 1'b1, 1'b0);
        rst_i = 1'b1;
        send(32'h1234_1234);
        step_chk("rm_rst", 32'h2000_2000, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        step_chk("rm_p1", 32'h2000_2000, 1'b1, 1'b0, 1'b0);
        step_chk("rm_p2", 32'h2000_2000, 1'b1, 1'b0, 1'b0);
        step_chk("rm_p3", 32'h2000_2000, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dac_slew_limiter.md
Name: dac_slew_limiter

Overview:
- Sits directly downstream of the PDH command core. Takes its sparse DAC update stream (tvalid pulses only on PS strobe) and drives the DAC AXIS continuously.
- Each of the two 14-bit channels moves toward its latest commanded target by at most a programmable step per update tick, so PS DAC writes never produce large output jumps into the laser/piezo driver.
- Also reports busy/settled status for PS callback.

Parameters:
- DAC_DATA_WIDTH, 14, bits per DAC channel (offset binary; 0x2000 is approximately 0 V).
- AXIS_TDATA_WIDTH, 32, packed word: {2'b00, ch2[13:0], 2'b00, ch1[13:0]}.
- DIV_WIDTH, 16, width of the tick prescaler divisor.

Ports:
- clk  in  1  FCLK_CLK0, 125 MHz.
- rst_i  in  1  synchronous, active-high reset.
- s_tdata_i  in  32  target word from the command core; bits 31:30 and 15:14 are ignored.
- s_tvalid_i  in  1  target update strobe; there is no tready, and every pulse is accepted.
- step_i  in  14  maximum change per tick, in codes; 0 means immediate (no limiting).
- div_i  in  DIV_WIDTH  tick period minus 1; 0 means a tick every cycle.
- bypass_i  in  1  when 1, the output follows the target immediately, identical to step_i==0.
- m_tdata_o  out  32  DAC word, same packing as the input, with pad bits driven to 0.
- m_tvalid_o  out  1  continuous-stream valid.
- busy_o  out  1  1 while either channel's output differs from its target.
- settled_o  out  1  one-cycle pulse when busy_o falls.

Behaviour:
- Clock and reset: one clock (clk), synchronous active-high reset (rst_i).
- Reset values:
  - tgt1/tgt2 and out1/out2 = 14'h2000, so m_tdata_o = 32'h2000_2000.
  - m_tvalid_o = 0, busy_o = 0, settled_o = 0.
  - Prescaler count = 0.
- After reset deasserts, m_tvalid_o = 1 from the first clock edge onward, and stays 1 until the next reset.
- Target latch: on an edge with s_tvalid_i=1, tgt1 <= s_tdata_i[13:0] and tgt2 <= s_tdata_i[29:16]. A new target overrides the old one immediately (retarget mid-slew). Slewing continues from the current output and the prescaler is not reset.
- Prescaler:
  - Counter runs 0..div_i; tick=1 in the cycle where count==div_i, then count wraps to 0.
  - If div_i is changed below the current count, the counter wraps to 0 on the next edge without a tick.
- Per-channel update, on an edge with tick=1:
  - diff = tgt - out, computed as 15-bit signed.
  - If diff==0: hold.
  - Else if |diff| <= step_i: out <= tgt (exact landing, no overshoot).
  - Else: out <= out + step_i if diff>0, or out - step_i if diff<0.
  - Unsigned range is 0..0x3FFF; the exact-landing rule guarantees no wrap at 0 or 0x3FFF.
- Immediate mode (step_i==0 or bypass_i==1): out <= tgt on every edge, regardless of tick.
- Latency:
  - s_tvalid_i sampled at edge k: target visible internally after edge k.
  - First output change at the first tick edge after k. With div_i=0 or immediate mode, that is edge k+1.
  - m_tdata_o is registered directly from out1/out2, with no extra stage.
- Channels are independent. Both share the tick, but each lands at its own time.
- busy_o is registered: busy_o <= (out1 != tgt1) || (out2 != tgt2), evaluated on next-state values.
- settled_o = 1 for one cycle on a busy_o 1->0 transition. A retarget equal to the current output causes no busy and no pulse.
- Reset mid-slew: on the next edge all state returns to reset values, and the pending target is discarded.
- s_tvalid_i during reset is ignored.

Decomposition:
- pdh_pkg (shared package) holds:
  - DAC_MID = 14'h2000.
  - DAC_DATA_WIDTH and the 32-bit pack/unpack field positions (CH1 [13:0], CH2 [29:16]).
  - Pack/unpack functions reused by the command core and this block.
- Sub-module slew_channel (instantiated twice) holds:
  - Inputs: clk, rst_i, load, load_val, tick, step, immediate.
  - Outputs: out, at_target.
- The parent holds the prescaler, packing, busy/settled logic and m_tvalid_o.

Test Plan:
- Reset and hold:
  - Stimulus: rst_i high for 3 cycles, then low.
  - Required: m_tdata_o=0x2000_2000 throughout; m_tvalid_o=0 during reset and 1 from the first post-reset edge; busy_o=0.
- Slew up:
  - Stimulus: step=0x100, div=0, s_tdata=0x2000_2400 pulsed at edge k.
  - Required: ch1 reads 0x2100, 0x2200, 0x2300, 0x2400 after edges k+1..k+4; ch2 stays 0x2000; busy_o=1 during the slew; settled_o pulses exactly once after edge k+4.
- Prescaled, non-multiple step:
  - Stimulus: div=3, step=0x300, ch2 target 0x1C00 (from 0x2000).
  - Required: ch2 changes only every 4th cycle: 0x1D00, then 0x1C00 (exact landing, no overshoot).
- Retarget mid-slew:
  - Stimulus: heading to 0x3000 with step 0x200; at output 0x2400, new target 0x2100.
  - Required: next tick gives 0x2200, then 0x2100; busy_o stays 1 with no settled pulse between; exactly one settled pulse at the end.
- Rail clamp and immediate mode:
  - Stimulus 1: step=0x3FFF, target 0x3FFF from 0x2000.
  - Required: 0x3FFF in one tick.
  - Stimulus 2: target 0x0000 with bypass_i=1.
  - Required: output is 0x0000 at edge k+1; no wrap at either rail.
- Reset mid-slew:
  - Stimulus: rst_i asserted while ch1=0x2600 and target=0x3000.
  - Required: after the reset edge, output=0x2000_2000 and busy_o=0; with no new s_tvalid_i after reset deasserts, the output stays 0x2000.
